// File: rtl/core_pkg.sv
// Shared core definitions: data width, ABI register indices and the packed-port slice helper.
package core_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned NREG_DEFAULT = 32;
   localparam int unsigned REG_ZERO     = 0;
   localparam int unsigned REG_A4       = 14;

   // Widest packed port vector the slice helper accepts; callers zero-extend into it.
   localparam int unsigned SLICE_MAX    = 1024;

   function automatic logic [SLICE_MAX-1:0] port_slice(
      input logic [SLICE_MAX-1:0] vec,
      input int unsigned          k,
      input int unsigned          w
   );
      logic [SLICE_MAX-1:0] mask;
      mask = ~({SLICE_MAX{1'b1}} << w);
      return (vec >> (k * w)) & mask;
   endfunction

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy bits: issue sets, writeback or flush clears, read ports look up pending sources.
module regfile_scoreboard_bits
   import core_pkg::*;
#(
   parameter  int unsigned NREG = NREG_DEFAULT,
   parameter  int unsigned NRD  = 2,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_en,
   input  logic [AW-1:0]     issue_rd,
   input  logic              flush,
   input  logic [NREG-1:0]   wr_hit,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_busy
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [AW-1:0]   ra [NRD];

   // Set after clear so a younger producer issued in the writeback cycle stays pending.
   always_comb begin
      busy_d = busy_q & ~wr_hit;
      if (issue_en && issue_rd != '0) begin
         busy_d[issue_rd] = 1'b1;
      end
      if (flush) begin
         busy_d = '0;
      end
      busy_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rd_busy = '0;
      for (int unsigned j = 0; j < NRD; j++) begin
         ra[j]      = AW'(port_slice(SLICE_MAX'(rd_addr), j, AW));
         rd_busy[j] = busy_q[ra[j]] & ~wr_hit[ra[j]];
      end
   end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port GPR file with prioritised writes, same-cycle bypass, hardwired x0 and a RAW scoreboard.
module regfile_mp_scoreboard
   import core_pkg::*;
#(
   parameter  int unsigned XLEN    = core_pkg::XLEN,
   parameter  int unsigned NREG    = NREG_DEFAULT,
   parameter  int unsigned NRD     = 2,
   parameter  int unsigned NWR     = 2,
   parameter  int unsigned DBG_REG = REG_A4,
   localparam int unsigned AW      = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_rd,
   input  logic                flush,
   output logic [XLEN-1:0]     dbg_data
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] wr_hit;
   logic [AW-1:0]   wa [NWR];
   logic [XLEN-1:0] wd [NWR];
   logic [AW-1:0]   ra [NRD];

   // regs_d is the post-write view, so it doubles as the bypass source for every read.
   always_comb begin
      wr_hit = '0;
      for (int unsigned r = 0; r < NREG; r++) begin
         regs_d[r] = regs_q[r];
      end
      for (int unsigned k = 0; k < NWR; k++) begin
         wa[k] = AW'(port_slice(SLICE_MAX'(wr_addr), k, AW));
         wd[k] = XLEN'(port_slice(SLICE_MAX'(wr_data), k, XLEN));
         if (wr_en[k] && wa[k] != '0) begin
            wr_hit[wa[k]] = 1'b1;
            regs_d[wa[k]] = wd[k];
         end
      end
      regs_d[REG_ZERO] = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            regs_q[r] <= regs_d[r];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned j = 0; j < NRD; j++) begin
         ra[j] = AW'(port_slice(SLICE_MAX'(rd_addr), j, AW));
         rd_data[j*XLEN +: XLEN] = regs_d[ra[j]];
      end
      dbg_data = regs_d[DBG_REG];
   end

   regfile_scoreboard_bits #(
      .NREG (NREG),
      .NRD  (NRD)
   ) u_sb (
      .clk      (clk),
      .reset    (reset),
      .issue_en (issue_en),
      .issue_rd (issue_rd),
      .flush    (flush),
      .wr_hit   (wr_hit),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy)
   );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed and randomised checks of regfile_mp_scoreboard against an array-based reference model.
module tb_regfile_mp_scoreboard;

   logic        clk;
   logic        reset;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic        flush;
   logic [31:0] dbg_data;

   int unsigned tests = 0;
   int unsigned fails = 0;

   logic [31:0] ref_regs [32];
   logic [31:0] ref_busy;

   regfile_mp_scoreboard #(
      .XLEN    (32),
      .NREG    (32),
      .NRD     (2),
      .NWR     (2),
      .DBG_REG (14)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .issue_en (issue_en),
      .issue_rd (issue_rd),
      .flush    (flush),
      .dbg_data (dbg_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic written_now(input logic [4:0] a);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 2; k++)
         if (wr_en[k] && wr_addr[k*5 +: 5] == a && a != 0) hit = 1'b1;
      return hit;
   endfunction

   // Expected read: x0 is zero, otherwise the highest-index matching write, otherwise storage.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v;
      if (a == 0) return 32'h0;
      v = ref_regs[a];
      for (int k = 0; k < 2; k++)
         if (wr_en[k] && wr_addr[k*5 +: 5] == a) v = wr_data[k*32 +: 32];
      return v;
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      return (a != 0) && ref_busy[a] && !written_now(a);
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) ref_regs[r] = 32'h0;
      ref_busy = 32'h0;
   endtask

   task automatic model_update();
      logic [31:0] nb;
      nb = ref_busy;
      for (int k = 0; k < 2; k++) begin
         if (wr_en[k] && wr_addr[k*5 +: 5] != 0) begin
            ref_regs[wr_addr[k*5 +: 5]] = wr_data[k*32 +: 32];
            nb[wr_addr[k*5 +: 5]] = 1'b0;
         end
      end
      if (issue_en && issue_rd != 0) nb[issue_rd] = 1'b1;
      if (flush) nb = 32'h0;
      ref_busy = nb;
   endtask

   task automatic check_all(input string tag);
      for (int j = 0; j < 2; j++) begin
         check({tag, "_rd"},   rd_data[j*32 +: 32], exp_rd(rd_addr[j*5 +: 5]));
         check({tag, "_busy"}, rd_busy[j],          exp_busy(rd_addr[j*5 +: 5]));
      end
      check({tag, "_dbg"}, dbg_data, exp_rd(5'd14));
   endtask

   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
   endtask

   task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
      wr_en[k] = 1'b1;
      wr_addr[k*5 +: 5] = a;
      wr_data[k*32 +: 32] = d;
   endtask

   task automatic rd(input int j, input logic [4:0] a);
      rd_addr[j*5 +: 5] = a;
   endtask

   task automatic issue(input logic [4:0] r);
      issue_en = 1'b1;
      issue_rd = r;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic tick(input string tag);
      settle();
      check_all(tag);
      adv();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      model_reset();
      rd(0, 5); rd(1, 14);
      #12;
      check_all("reset0");
      reset = 1'b1;
      @(posedge clk);
      #1;

      // reset mid-cycle after loading x5
      idle(); wr(0, 5, 32'h7C); rd(0, 5);
      tick("load_x5");
      idle(); rd(0, 5);
      #1;
      check("x5_loaded", rd_data[31:0], 32'h7C);
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_x5_now", rd_data[31:0], 32'h0);
      check("rst_busy", rd_busy, 2'b00);
      reset = 1'b1;
      #1;
      tick("post_rst");
      idle(); wr(0, 5, 32'hAA); rd(0, 5);
      tick("wr_x5_aa");
      idle(); rd(0, 5);
      settle();
      check("x5_aa", rd_data[31:0], 32'hAA);
      adv();

      // write priority
      idle(); wr(0, 10, 32'h11); wr(1, 10, 32'h22); rd(0, 10);
      settle();
      check_all("prio");
      check("prio_byp", rd_data[31:0], 32'h22);
      adv();
      idle(); rd(0, 10);
      settle();
      check("prio_store", rd_data[31:0], 32'h22);
      adv();

      // x0 writes discarded
      idle(); wr(1, 0, 32'hFFFF); rd(0, 0); rd(1, 0);
      settle();
      check("x0_byp", rd_data[31:0], 32'h0);
      adv();
      idle(); rd(1, 0);
      settle();
      check("x0_store", rd_data[63:32], 32'h0);
      adv();

      // bypass and debug mirror
      idle(); wr(0, 7, 32'h1234); wr(1, 14, 32'hCAFE); rd(0, 7);
      settle();
      check("byp_x7", rd_data[31:0], 32'h1234);
      check("dbg_x14", dbg_data, 32'hCAFE);
      check_all("byp");
      adv();

      // scoreboard lifetime of x9
      idle(); issue(9); rd(0, 9);
      settle();
      check("sb_issue_cyc", rd_busy[0], 1'b0);
      adv();
      for (int i = 0; i < 3; i++) begin
         idle(); rd(0, 9);
         settle();
         check("sb_busy", rd_busy[0], 1'b1);
         adv();
      end
      idle(); wr(0, 9, 32'h55); rd(0, 9);
      settle();
      check("sb_wb_busy", rd_busy[0], 1'b0);
      check("sb_wb_data", rd_data[31:0], 32'h55);
      adv();
      idle(); rd(0, 9);
      settle();
      check("sb_after", rd_busy[0], 1'b0);
      adv();

      // set and clear collide on x12
      idle(); issue(12); wr(1, 12, 32'h77); rd(0, 12);
      tick("coll");
      idle(); rd(0, 12);
      settle();
      check("coll_busy", rd_busy[0], 1'b1);
      adv();

      // flush with simultaneous issue and write
      idle(); issue(3);  tick("iss3");
      idle(); issue(4);  tick("iss4");
      idle(); issue(31); tick("iss31");
      idle(); rd(0, 3); rd(1, 31);
      settle();
      check("pre_flush", rd_busy, 2'b11);
      adv();
      idle(); flush = 1'b1; issue(8); wr(0, 20, 32'h99);
      tick("flush");
      idle(); rd(0, 3); rd(1, 4);
      settle();
      check("flush_34", rd_busy, 2'b00);
      rd(0, 31); rd(1, 8);
      #1;
      check("flush_31_8", rd_busy, 2'b00);
      rd(0, 20);
      #1;
      check("flush_wr_x20", rd_data[31:0], 32'h99);
      adv();

      // randomised traffic
      for (int i = 0; i < 400; i++) begin
         idle();
         wr_en = 2'($urandom_range(0, 3));
         for (int k = 0; k < 2; k++) begin
            wr_addr[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                             : 5'($urandom_range(0, 7));
            wr_data[k*32 +: 32] = $urandom;
         end
         for (int j = 0; j < 2; j++) rd_addr[j*5 +: 5] = 5'($urandom_range(0, 15));
         issue_en = ($urandom_range(0, 1) == 1);
         issue_rd = 5'($urandom_range(0, 15));
         flush    = ($urandom_range(0, 15) == 0);
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
